// File: rtl/alu_reservation_station_if.sv
// Dispatch, broadcast-snoop, flush and issue signals of the ALU reservation station.
// The dispatcher/ROB/bus side uses the master modport; the station uses the slave modport.
interface alu_reservation_station_if #(
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6
);
  logic                  disp_en_in;
  logic [OP_WIDTH-1:0]   disp_op_in;
  logic [ID_WIDTH-1:0]   disp_vj_in;
  logic [ID_WIDTH-1:0]   disp_vk_in;
  logic [ROB_WIDTH-1:0]  disp_qj_in;
  logic [ROB_WIDTH-1:0]  disp_qk_in;
  logic [ID_WIDTH-1:0]   disp_a_in;
  logic [ROB_WIDTH-1:0]  disp_dest_in;
  logic [ADDR_WIDTH-1:0] disp_pc_in;
  logic                  rs_full_out;
  logic [ROB_WIDTH-1:0]  alu_h_in;
  logic [ID_WIDTH-1:0]   alu_v_in;
  logic [ROB_WIDTH-1:0]  lsb_h_in;
  logic [ID_WIDTH-1:0]   lsb_v_in;
  logic                  rob_rs_rst_in;
  logic [OP_WIDTH-1:0]   rs_alu_op_out;
  logic [ID_WIDTH-1:0]   rs_alu_vj_out;
  logic [ID_WIDTH-1:0]   rs_alu_vk_out;
  logic [ID_WIDTH-1:0]   rs_alu_a_out;
  logic [ROB_WIDTH-1:0]  rs_alu_dest_out;
  logic [ADDR_WIDTH-1:0] rs_alu_pc_out;

  modport master (
    output disp_en_in, disp_op_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
    output disp_a_in, disp_dest_in, disp_pc_in,
    output alu_h_in, alu_v_in, lsb_h_in, lsb_v_in, rob_rs_rst_in,
    input  rs_full_out, rs_alu_op_out, rs_alu_vj_out, rs_alu_vk_out, rs_alu_a_out,
    input  rs_alu_dest_out, rs_alu_pc_out
  );

  modport slave (
    input  disp_en_in, disp_op_in, disp_vj_in, disp_vk_in, disp_qj_in, disp_qk_in,
    input  disp_a_in, disp_dest_in, disp_pc_in,
    input  alu_h_in, alu_v_in, lsb_h_in, lsb_v_in, rob_rs_rst_in,
    output rs_full_out, rs_alu_op_out, rs_alu_vj_out, rs_alu_vk_out, rs_alu_a_out,
    output rs_alu_dest_out, rs_alu_pc_out
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops until operand tags resolve, then issues the
// lowest-index ready entry to the combinational ALU, one per cycle.
module alu_reservation_station #(
  parameter int unsigned RS_SIZE    = 16,
  parameter int unsigned ROB_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 6
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  alu_reservation_station_if.slave bus
);
  localparam int unsigned IdxW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]    busy_q;
  logic [OP_WIDTH-1:0]   op_q   [RS_SIZE];
  logic [ID_WIDTH-1:0]   vj_q   [RS_SIZE];
  logic [ID_WIDTH-1:0]   vk_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0]  qj_q   [RS_SIZE];
  logic [ROB_WIDTH-1:0]  qk_q   [RS_SIZE];
  logic [ID_WIDTH-1:0]   a_q    [RS_SIZE];
  logic [ROB_WIDTH-1:0]  dest_q [RS_SIZE];
  logic [ADDR_WIDTH-1:0] pc_q   [RS_SIZE];

  logic [OP_WIDTH-1:0]   iss_op_q;
  logic [ID_WIDTH-1:0]   iss_vj_q;
  logic [ID_WIDTH-1:0]   iss_vk_q;
  logic [ID_WIDTH-1:0]   iss_a_q;
  logic [ROB_WIDTH-1:0]  iss_dest_q;
  logic [ADDR_WIDTH-1:0] iss_pc_q;

  logic            free_vld;
  logic [IdxW-1:0] free_idx;
  logic            sel_vld;
  logic [IdxW-1:0] sel_idx;
  logic [ID_WIDTH-1:0]  byp_vj, byp_vk;
  logic [ROB_WIDTH-1:0] byp_qj, byp_qk;

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = IdxW'(i);
      end
      if (busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0) begin
        sel_vld = 1'b1;
        sel_idx = IdxW'(i);
      end
    end
  end

  // No free entry is the same condition as busy count reaching RS_SIZE.
  assign bus.rs_full_out = ~free_vld;

  always_comb begin
    byp_vj = bus.disp_vj_in;
    byp_qj = bus.disp_qj_in;
    byp_vk = bus.disp_vk_in;
    byp_qk = bus.disp_qk_in;
    if (bus.disp_qj_in != '0 && bus.disp_qj_in == bus.alu_h_in) begin
      byp_vj = bus.alu_v_in;
      byp_qj = '0;
    end else if (bus.disp_qj_in != '0 && bus.disp_qj_in == bus.lsb_h_in) begin
      byp_vj = bus.lsb_v_in;
      byp_qj = '0;
    end
    if (bus.disp_qk_in != '0 && bus.disp_qk_in == bus.alu_h_in) begin
      byp_vk = bus.alu_v_in;
      byp_qk = '0;
    end else if (bus.disp_qk_in != '0 && bus.disp_qk_in == bus.lsb_h_in) begin
      byp_vk = bus.lsb_v_in;
      byp_qk = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      iss_op_q   <= '0;
      iss_vj_q   <= '0;
      iss_vk_q   <= '0;
      iss_a_q    <= '0;
      iss_dest_q <= '0;
      iss_pc_q   <= '0;
    end else if (rdy_in) begin
      if (bus.rob_rs_rst_in) begin
        busy_q     <= '0;
        iss_op_q   <= '0;
        iss_vj_q   <= '0;
        iss_vk_q   <= '0;
        iss_a_q    <= '0;
        iss_dest_q <= '0;
        iss_pc_q   <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            if (qj_q[i] != '0 && qj_q[i] == bus.alu_h_in) begin
              vj_q[i] <= bus.alu_v_in;
              qj_q[i] <= '0;
            end else if (qj_q[i] != '0 && qj_q[i] == bus.lsb_h_in) begin
              vj_q[i] <= bus.lsb_v_in;
              qj_q[i] <= '0;
            end
            if (qk_q[i] != '0 && qk_q[i] == bus.alu_h_in) begin
              vk_q[i] <= bus.alu_v_in;
              qk_q[i] <= '0;
            end else if (qk_q[i] != '0 && qk_q[i] == bus.lsb_h_in) begin
              vk_q[i] <= bus.lsb_v_in;
              qk_q[i] <= '0;
            end
          end
        end
        if (sel_vld) begin
          busy_q[sel_idx] <= 1'b0;
          iss_op_q   <= op_q[sel_idx];
          iss_vj_q   <= vj_q[sel_idx];
          iss_vk_q   <= vk_q[sel_idx];
          iss_a_q    <= a_q[sel_idx];
          iss_dest_q <= dest_q[sel_idx];
          iss_pc_q   <= pc_q[sel_idx];
        end else begin
          iss_op_q   <= '0;
          iss_vj_q   <= '0;
          iss_vk_q   <= '0;
          iss_a_q    <= '0;
          iss_dest_q <= '0;
          iss_pc_q   <= '0;
        end
        // The free entry is never busy, so it cannot collide with the wakeup or issue above.
        if (bus.disp_en_in && free_vld) begin
          busy_q[free_idx] <= 1'b1;
          op_q[free_idx]   <= bus.disp_op_in;
          vj_q[free_idx]   <= byp_vj;
          vk_q[free_idx]   <= byp_vk;
          qj_q[free_idx]   <= byp_qj;
          qk_q[free_idx]   <= byp_qk;
          a_q[free_idx]    <= bus.disp_a_in;
          dest_q[free_idx] <= bus.disp_dest_in;
          pc_q[free_idx]   <= bus.disp_pc_in;
        end
      end
    end
  end

  assign bus.rs_alu_op_out   = iss_op_q;
  assign bus.rs_alu_vj_out   = iss_vj_q;
  assign bus.rs_alu_vk_out   = iss_vk_q;
  assign bus.rs_alu_a_out    = iss_a_q;
  assign bus.rs_alu_dest_out = iss_dest_q;
  assign bus.rs_alu_pc_out   = iss_pc_q;
endmodule
